// File: rtl/switch_debounce_sync.sv
`default_nettype none
//==============================================================================
// Module      : switch_debounce_sync
// Description : Conditions the raw slide switches ahead of the switches_export
//               PIO input. Each switch passes through a 2-flop synchroniser and
//               then a per-channel stable-time filter. A one-cycle change pulse
//               is raised whenever a debounced level toggles.
//               Optional feature macro: SW_CHANGE_LATCH_EN (adds sw_clear input
//               and sw_sticky output, a latched "switch moved" flag).
// Revision    : 1.0 - initial release
//==============================================================================
module switch_debounce_sync #(
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic            clk_clk,
    input  logic            reset_reset_n,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_db,
    output logic [N_SW-1:0] sw_change,
    output logic            any_change
`ifdef SW_CHANGE_LATCH_EN
    ,
    input  logic [N_SW-1:0] sw_clear,
    output logic [N_SW-1:0] sw_sticky
`endif
);

    // Counter only has to reach DEBOUNCE_CYCLES-1, one spare code is harmless.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [N_SW-1:0] r_s1;
    logic [N_SW-1:0] r_s2;
    logic [N_SW-1:0] w_change_next;
    logic [N_SW-1:0] r_change;
    logic            r_any_change;

    // Two-flop synchroniser; only r_s2 is ever looked at by the filter.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw_raw;
            r_s2 <= r_s1;
        end
    end

    generate
        for (genvar gi = 0; gi < N_SW; gi++) begin : g_chan
            logic [CNT_W-1:0] r_cnt;
            logic             r_db;
            logic             w_mismatch;
            logic             w_accept;

            // A disagreement that has already lasted DEBOUNCE_CYCLES-1 edges
            // is accepted on this edge; with DEBOUNCE_CYCLES == 1 that is the
            // very first mismatch edge.
            assign w_mismatch         = r_s2[gi] ^ r_db;
            assign w_accept           = w_mismatch && (r_cnt == c_cnt_last);
            assign w_change_next[gi]  = w_accept;
            assign sw_db[gi]          = r_db;

            // Stable-time counter: any agreement discards the partial count,
            // so a burst shorter than the window never reaches r_db.
            always_ff @(posedge clk_clk or negedge reset_reset_n) begin
                if (!reset_reset_n) begin
                    r_cnt <= '0;
                    r_db  <= 1'b0;
                end else if (!w_mismatch || w_accept) begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_db <= r_s2[gi];
                    end
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
        end
    endgenerate

    // Change pulses and their OR are registered together so they line up.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_change     <= '0;
            r_any_change <= 1'b0;
        end else begin
            r_change     <= w_change_next;
            r_any_change <= |w_change_next;
        end
    end

    assign sw_change  = r_change;
    assign any_change = r_any_change;

`ifdef SW_CHANGE_LATCH_EN
    logic [N_SW-1:0] r_sticky;

    // Sticky flag: a new change beats a simultaneous software clear.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (r_sticky & ~sw_clear) | w_change_next;
        end
    end

    assign sw_sticky = r_sticky;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce_sync.sv
`default_nettype none
//==============================================================================
// Module      : tb_switch_debounce_sync
// Description : Self-checking bench for switch_debounce_sync (N_SW=10,
//               DEBOUNCE_CYCLES=4). A cycle model pushes expected outputs into
//               a queue on every rising edge; a checker pops and compares them
//               on the falling edge. Directed checks cover latency, bounce,
//               reset behaviour and (with SW_CHANGE_LATCH_EN) the sticky flag.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_switch_debounce_sync;

    localparam int N_SW = 10;
    localparam int DEB  = 4;

    logic            clk_clk;
    logic            reset_reset_n;
    logic [N_SW-1:0] sw_raw;
    logic [N_SW-1:0] sw_db;
    logic [N_SW-1:0] sw_change;
    logic            any_change;
`ifdef SW_CHANGE_LATCH_EN
    logic [N_SW-1:0] sw_clear;
    logic [N_SW-1:0] sw_sticky;
`endif

    switch_debounce_sync #(
        .N_SW            (N_SW),
        .DEBOUNCE_CYCLES (DEB)
    ) u_dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .sw_raw        (sw_raw),
        .sw_db         (sw_db),
        .sw_change     (sw_change),
        .any_change    (any_change)
`ifdef SW_CHANGE_LATCH_EN
        ,
        .sw_clear      (sw_clear),
        .sw_sticky     (sw_sticky)
`endif
    );

    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [N_SW-1:0] db;
        logic [N_SW-1:0] chg;
        logic            any;
    } exp_t;

    exp_t exp_q[$];

    logic [N_SW-1:0] m_s1  = '0;
    logic [N_SW-1:0] m_s2  = '0;
    logic [N_SW-1:0] m_db  = '0;
    logic [N_SW-1:0] m_chg = '0;
    int              m_cnt [N_SW];

    // Reference model of the filter, evaluated at every edge.
    initial begin
        for (int i = 0; i < N_SW; i++) m_cnt[i] = 0;
        forever begin
            @(posedge clk_clk or negedge reset_reset_n);
            if (!reset_reset_n) begin
                m_s1 = '0;
                m_s2 = '0;
                m_db = '0;
                for (int i = 0; i < N_SW; i++) m_cnt[i] = 0;
                exp_q.delete();
            end else begin
                m_chg = '0;
                for (int i = 0; i < N_SW; i++) begin
                    if (m_s2[i] == m_db[i]) begin
                        m_cnt[i] = 0;
                    end else if (m_cnt[i] >= DEB - 1) begin
                        m_db[i]  = m_s2[i];
                        m_cnt[i] = 0;
                        m_chg[i] = 1'b1;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
                m_s2 = m_s1;
                m_s1 = sw_raw;
                exp_q.push_back('{db: m_db, chg: m_chg, any: (m_chg != '0)});
            end
        end
    end

    int pulse_cnt [N_SW];

    // Falling-edge checker and per-channel pulse counters.
    initial begin
        exp_t e;
        for (int i = 0; i < N_SW; i++) pulse_cnt[i] = 0;
        forever begin
            @(negedge clk_clk);
            if (reset_reset_n) begin
                for (int i = 0; i < N_SW; i++) pulse_cnt[i] += int'(sw_change[i]);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("sb_db",  32'(sw_db),      32'(e.db));
                    check_eq("sb_chg", 32'(sw_change),  32'(e.chg));
                    check_eq("sb_any", 32'(any_change), 32'(e.any));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk_clk);
        #2;
    endtask

    task automatic clr_counts();
        for (int i = 0; i < N_SW; i++) pulse_cnt[i] = 0;
    endtask

    // Counts edges (first edge after the call is 1) until masked sw_db matches.
    task automatic wait_db(input logic [N_SW-1:0] mask, input logic [N_SW-1:0] val, output int n);
        n = 99;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk_clk);
            #1;
            if ((sw_db & mask) == val) begin
                n = i;
                break;
            end
        end
        #1;
    endtask

    function automatic int total_pulses();
        int t = 0;
        for (int i = 0; i < N_SW; i++) t += pulse_cnt[i];
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        sw_raw        = '0;
        reset_reset_n = 1'b0;
`ifdef SW_CHANGE_LATCH_EN
        sw_clear      = '0;
`endif
        step(3);
        check_eq("rst_db",  32'(sw_db),      32'h0);
        check_eq("rst_chg", 32'(sw_change),  32'h0);
        check_eq("rst_any", 32'(any_change), 32'h0);

        // Release with all switches low: nothing happens.
        clr_counts();
        reset_reset_n = 1'b1;
        step(20);
        check_eq("idle_db",    32'(sw_db),          32'h0);
        check_eq("idle_pulse", 32'(total_pulses()), 32'h0);

        // Switches held high through reset are re-accepted after release.
        reset_reset_n = 1'b0;
        sw_raw        = '1;
        step(3);
        reset_reset_n = 1'b1;
        wait_db('1, 10'h3FF, n);
        check_eq("hi_rst_lat", 32'(n),          32'd6);
        check_eq("hi_rst_chg", 32'(sw_change),  32'h3FF);
        check_eq("hi_rst_any", 32'(any_change), 32'h1);
        step(1);
        check_eq("hi_rst_chg_off", 32'(sw_change),  32'h0);
        check_eq("hi_rst_any_off", 32'(any_change), 32'h0);
        sw_raw = '0;
        step(10);
        check_eq("hi_rst_back", 32'(sw_db), 32'h0);

        // Single channel rise.
        clr_counts();
        sw_raw[0] = 1'b1;
        wait_db(10'h001, 10'h001, n);
        check_eq("ch0_lat", 32'(n),         32'd6);
        check_eq("ch0_db",  32'(sw_db),     32'h001);
        check_eq("ch0_chg", 32'(sw_change), 32'h001);
        step(1);
        check_eq("ch0_chg_off", 32'(sw_change),    32'h0);
        check_eq("ch0_pulses",  32'(pulse_cnt[0]), 32'd1);

        // Bounce on channel 3: 3-cycle highs never get accepted.
        clr_counts();
        sw_raw[3] = 1'b1; step(3);
        sw_raw[3] = 1'b0; step(2);
        sw_raw[3] = 1'b1; step(3);
        sw_raw[3] = 1'b0; step(2);
        check_eq("bnc_db",     32'(sw_db[3]),     32'h0);
        check_eq("bnc_nopulse", 32'(pulse_cnt[3]), 32'd0);
        sw_raw[3] = 1'b1;
        wait_db(10'h008, 10'h008, n);
        check_eq("bnc_lat", 32'(n), 32'd6);
        step(1);
        check_eq("bnc_pulses", 32'(pulse_cnt[3]), 32'd1);

        // Two channels changing on the same edge.
        sw_raw = '0;
        step(10);
        check_eq("multi_pre", 32'(sw_db), 32'h0);
        sw_raw = 10'h201;
        wait_db('1, 10'h201, n);
        check_eq("multi_lat", 32'(n),          32'd6);
        check_eq("multi_chg", 32'(sw_change),  32'h201);
        check_eq("multi_any", 32'(any_change), 32'h1);
        sw_raw = '0;
        wait_db('1, 10'h000, n);
        check_eq("multi_fall_lat", 32'(n),         32'd6);
        check_eq("multi_fall_chg", 32'(sw_change), 32'h201);

        // Reset in the middle of a count on channel 5.
        sw_raw = 10'h200;
        wait_db('1, 10'h200, n);
        sw_raw = 10'h220;
        step(4);
        reset_reset_n = 1'b0;
        #1;
        check_eq("mid_rst_db",  32'(sw_db),      32'h0);
        check_eq("mid_rst_chg", 32'(sw_change),  32'h0);
        check_eq("mid_rst_any", 32'(any_change), 32'h0);
        step(3);
        reset_reset_n = 1'b1;
        wait_db('1, 10'h220, n);
        check_eq("mid_rst_lat", 32'(n),         32'd6);
        check_eq("mid_rst_chg_on", 32'(sw_change), 32'h220);

`ifdef SW_CHANGE_LATCH_EN
        // Sticky flag: set by a change, cleared by software, set wins a tie.
        sw_raw = '0;
        step(10);
        sw_clear = '1;
        step(1);
        sw_clear = '0;
        check_eq("stk_clean", 32'(sw_sticky), 32'h0);
        sw_raw[2] = 1'b1;
        wait_db(10'h004, 10'h004, n);
        check_eq("stk_set", 32'(sw_sticky[2]), 32'h1);
        step(3);
        check_eq("stk_hold", 32'(sw_sticky[2]), 32'h1);
        sw_clear[2] = 1'b1;
        step(1);
        sw_clear[2] = 1'b0;
        check_eq("stk_clr", 32'(sw_sticky[2]), 32'h0);
        sw_raw[2] = 1'b0;
        step(5);
        sw_clear[2] = 1'b1;
        step(1);
        sw_clear[2] = 1'b0;
        check_eq("stk_tie_chg", 32'(sw_change[2]), 32'h1);
        check_eq("stk_tie",     32'(sw_sticky[2]), 32'h1);
`endif

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
